// File: rtl/traffic.sv
// Pedestrian-crossing controller: one car head, one pedestrian head, latched push-button request.
// Optional macro TRAFFIC_WAIT_LAMP_EN adds the wait_p lamp, which shows the request latch.
module traffic #(
    parameter int CAR_GREEN_MIN = 8,
    parameter int CAR_YELLOW    = 3,
    parameter int ALL_RED       = 2,
    parameter int PED_GREEN     = 10,
    parameter int PED_YELLOW    = 3,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic green_c,
    output logic yellow_c,
    output logic red_c,
    output logic green_p,
    output logic yellow_p,
    output logic red_p
`ifdef TRAFFIC_WAIT_LAMP_EN
    ,
    output logic wait_p
`endif
);

    typedef enum logic [2:0] {
        CAR_GO   = 3'd0,
        CAR_WARN = 3'd1,
        CLR1     = 3'd2,
        PED_GO   = 3'd3,
        PED_WARN = 3'd4,
        CLR2     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] GMIN_L = CNT_W'(CAR_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] CYEL_L = CNT_W'(CAR_YELLOW - 1);
    localparam logic [CNT_W-1:0] ARED_L = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] PGRN_L = CNT_W'(PED_GREEN - 1);
    localparam logic [CNT_W-1:0] PYEL_L = CNT_W'(PED_YELLOW - 1);

    // Lamp order: {green_c, yellow_c, red_c, green_p, yellow_p, red_p}
    localparam logic [5:0] L_CAR_GO   = 6'b100_001;
    localparam logic [5:0] L_CAR_WARN = 6'b010_001;
    localparam logic [5:0] L_ALL_RED  = 6'b001_001;
    localparam logic [5:0] L_PED_GO   = 6'b001_100;
    localparam logic [5:0] L_PED_WARN = 6'b001_010;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic [5:0]       lamp_q, lamp_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        req_d   = req_q;
        case (state_q)
            CAR_GO: begin
                req_d = req_q | button;
                if (cnt_q == GMIN_L) begin
                    if (req_q | button) state_d = CAR_WARN;
                    else                cnt_d   = cnt_q;
                end
            end
            CAR_WARN: begin
                req_d = req_q | button;
                if (cnt_q == CYEL_L) state_d = CLR1;
            end
            CLR1: begin
                req_d = req_q | button;
                // Clearing on PED_GO entry wins over a press on the same edge.
                if (cnt_q == ARED_L) begin
                    state_d = PED_GO;
                    req_d   = 1'b0;
                end
            end
            PED_GO:   if (cnt_q == PGRN_L) state_d = PED_WARN;
            PED_WARN: if (cnt_q == PYEL_L) state_d = CLR2;
            CLR2:     if (cnt_q == ARED_L) state_d = CAR_GO;
            default:  state_d = CAR_GO;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Lamps are decoded from the next state so they line up with state_q.
    always_comb begin
        lamp_d = L_CAR_GO;
        case (state_d)
            CAR_GO:   lamp_d = L_CAR_GO;
            CAR_WARN: lamp_d = L_CAR_WARN;
            CLR1:     lamp_d = L_ALL_RED;
            PED_GO:   lamp_d = L_PED_GO;
            PED_WARN: lamp_d = L_PED_WARN;
            CLR2:     lamp_d = L_ALL_RED;
            default:  lamp_d = L_CAR_GO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CAR_GO;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            lamp_q  <= L_CAR_GO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            lamp_q  <= lamp_d;
        end
    end

    assign {green_c, yellow_c, red_c, green_p, yellow_p, red_p} = lamp_q;

`ifdef TRAFFIC_WAIT_LAMP_EN
    assign wait_p = req_q;
`endif

endmodule

// File: tb/tb_traffic.sv
// Directed bench for the pedestrian-crossing controller; expected lamp patterns are hand-derived
// from edge offsets relative to the press that starts each pedestrian phase.
module tb_traffic;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button = 1'b0;
    logic green_c, yellow_c, red_c, green_p, yellow_p, red_p;
`ifdef TRAFFIC_WAIT_LAMP_EN
    logic wait_p;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] S_GO   = 6'b100_001;
    localparam logic [5:0] S_WARN = 6'b010_001;
    localparam logic [5:0] S_CLR  = 6'b001_001;
    localparam logic [5:0] S_PGO  = 6'b001_100;
    localparam logic [5:0] S_PW   = 6'b001_010;

    traffic dut (
        .clk      (clk),
        .rst      (rst),
        .button   (button),
        .green_c  (green_c),
        .yellow_c (yellow_c),
        .red_c    (red_c),
        .green_p  (green_p),
        .yellow_p (yellow_p),
        .red_p    (red_p)
`ifdef TRAFFIC_WAIT_LAMP_EN
        ,
        .wait_p   (wait_p)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] lamps();
        return {green_c, yellow_c, red_c, green_p, yellow_p, red_p};
    endfunction

    // d = edges since the edge that moved CAR_GO -> CAR_WARN (d=0 is that edge).
    function automatic logic [5:0] ped_seq(input int d);
        if (d < 0)  return S_GO;
        if (d < 3)  return S_WARN;
        if (d < 5)  return S_CLR;
        if (d < 15) return S_PGO;
        if (d < 18) return S_PW;
        if (d < 20) return S_CLR;
        return S_GO;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // After this returns, the next posedge is edge 1 after reset.
    task automatic do_reset();
        button = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        button = 1'b1;
        #1;
        total++;
        if (lamps() !== S_GO) begin
            bad++;
            $display("FAIL reset_async lamps got=%b exp=%b", lamps(), S_GO);
        end
`ifdef TRAFFIC_WAIT_LAMP_EN
        total++;
        if (wait_p !== 1'b0) begin
            bad++;
            $display("FAIL reset_wait got=%b exp=0", wait_p);
        end
`endif
        step();
        total++;
        if (lamps() !== S_GO) begin
            bad++;
            $display("FAIL reset_held lamps got=%b exp=%b", lamps(), S_GO);
        end
        button = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle();
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            step();
            total++;
            if (lamps() !== S_GO) begin
                bad++;
                $display("FAIL idle edge=%0d lamps got=%b exp=%b", k, lamps(), S_GO);
            end
        end
    endtask

    task automatic test_ped_cycle();
        do_reset();
        for (int k = 1; k <= 50; k++) begin
            button = (k == 20);
            step();
            total++;
            if (lamps() !== ped_seq(k - 20)) begin
                bad++;
                $display("FAIL ped_cycle edge=%0d lamps got=%b exp=%b", k, lamps(), ped_seq(k - 20));
            end
        end
        button = 1'b0;
    endtask

    // Early press waits for minimum green, and presses during PED_GO are ignored.
    task automatic test_early_press();
        do_reset();
        for (int k = 1; k <= 45; k++) begin
            button = (k == 2) || (k == 16);
            step();
            total++;
            if (lamps() !== ped_seq(k - 8)) begin
                bad++;
                $display("FAIL early_press edge=%0d lamps got=%b exp=%b", k, lamps(), ped_seq(k - 8));
            end
        end
        button = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        do_reset();
        button = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            exp = (k < 36) ? ped_seq(k - 8) : ped_seq(k - 36);
            total++;
            if (lamps() !== exp) begin
                bad++;
                $display("FAIL held_button edge=%0d lamps got=%b exp=%b", k, lamps(), exp);
            end
        end
        button = 1'b0;
    endtask

    task automatic test_toggle();
        int phases = 0;
        logic prev_gp = 1'b0;
        logic [2:0] car, ped;
        do_reset();
        for (int k = 1; k <= 500; k++) begin
            button = k[0];
            step();
            car = {green_c, yellow_c, red_c};
            ped = {green_p, yellow_p, red_p};
            total++;
            if (!$onehot(car) || !$onehot(ped) || (green_c & green_p)) begin
                bad++;
                $display("FAIL toggle_invariant edge=%0d car=%b ped=%b", k, car, ped);
            end
            if (green_p && !prev_gp) phases++;
            prev_gp = green_p;
        end
        button = 1'b0;
        total++;
        if (phases < 10) begin
            bad++;
            $display("FAIL toggle_phases got=%0d exp>=10", phases);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            button = (k == 2);
            step();
        end
        total++;
        if (lamps() !== S_PGO) begin
            bad++;
            $display("FAIL mid_pre lamps got=%b exp=%b", lamps(), S_PGO);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (lamps() !== S_GO) begin
            bad++;
            $display("FAIL mid_reset lamps got=%b exp=%b", lamps(), S_GO);
        end
`ifdef TRAFFIC_WAIT_LAMP_EN
        total++;
        if (wait_p !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_wait got=%b exp=0", wait_p);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            total++;
            if (lamps() !== S_GO) begin
                bad++;
                $display("FAIL mid_after edge=%0d lamps got=%b exp=%b", k, lamps(), S_GO);
            end
        end
    endtask

`ifdef TRAFFIC_WAIT_LAMP_EN
    task automatic test_wait_lamp();
        logic exp;
        do_reset();
        total++;
        if (wait_p !== 1'b0) begin
            bad++;
            $display("FAIL wait_init got=%b exp=0", wait_p);
        end
        for (int k = 1; k <= 20; k++) begin
            button = (k == 3);
            step();
            exp = (k >= 3) && (k < 13);
            total++;
            if (wait_p !== exp) begin
                bad++;
                $display("FAIL wait_lamp edge=%0d got=%b exp=%b", k, wait_p, exp);
            end
        end
        button = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_ped_cycle();
        test_early_press();
        test_back_to_back();
        test_toggle();
        test_reset_mid();
`ifdef TRAFFIC_WAIT_LAMP_EN
        test_wait_lamp();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
